// File: rtl/run_ctrl.sv
// Host-side run controller: preloads data memory while the core is held in
// reset, then releases it, asserts req and times the run until done or timeout.
module run_ctrl #(
    parameter int unsigned AW      = 8,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RST  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int unsigned    RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYC - 1);
    localparam logic [CW-1:0]  TO_VAL   = CW'(TIMEOUT);

    logic [2:0]    state;
    logic [AW-1:0] ptr;
    logic [RW-1:0] rst_cnt;
    logic [CW-1:0] cyc_inc;

    assign cyc_inc    = cycles + CW'(1);
    assign ld_ready   = (state == ST_LOAD);
    assign core_req   = (state == ST_RUN);
    assign core_reset = (state != ST_RUN);
    assign busy       = (state == ST_LOAD) || (state == ST_RST) || (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            rst_cnt   <= '0;
            cycles    <= '0;
            timed_out <= 1'b0;
            finished  <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_dat   <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            finished  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        ptr       <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Pointer wraps naturally at 2^AW; later bytes overwrite.
                    if (ld_valid) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= ptr;
                        mem_dat   <= ld_data;
                        ptr       <= ptr + AW'(1);
                        if (ld_last) begin
                            state   <= ST_RST;
                            rst_cnt <= '0;
                        end
                    end
                end
                ST_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                ST_RUN: begin
                    // core_done wins over a timeout landing in the same cycle.
                    if (core_done) begin
                        state    <= ST_DONE;
                        finished <= 1'b1;
                    end else begin
                        cycles <= cyc_inc;
                        if (cyc_inc == TO_VAL) begin
                            state     <= ST_DONE;
                            timed_out <= 1'b1;
                            finished  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: stimulus pushes expected memory writes and run
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_run_ctrl;

    localparam int unsigned AW      = 2;
    localparam int unsigned CW      = 16;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned RST_CYC = 2;
    localparam int          DEPTH   = 1 << AW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          core_done;
    logic          core_reset;
    logic          core_req;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycles;

    run_ctrl #(.AW(AW), .CW(CW), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .core_done(core_done), .core_reset(core_reset), .core_req(core_req),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat),
        .busy(busy), .finished(finished), .timed_out(timed_out), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cyc; int to; } fin_t;

    wr_t        wq[$];
    fin_t       fq[$];
    logic [7:0] bq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ptr_m    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented write / finish pulse must match the next expectation.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write (t=%0t)",
                         mem_addr, mem_dat, $time);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), w.addr);
                chk("wr_data", 32'(mem_dat), w.data);
            end
        end
        if (finished === 1'b1) begin
            if (fq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_finished: got pulse expected none (t=%0t)", $time);
            end else begin
                fin_t f;
                f = fq.pop_front();
                chk("fin_cycles", 32'(cycles), f.cyc);
                chk("fin_timed_out", 32'(timed_out), f.to);
                chk("fin_core_reset", 32'(core_reset), 1);
                chk("fin_core_req", 32'(core_req), 0);
                chk("fin_busy", 32'(busy), 0);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_core_req", 32'(core_req), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_dat", 32'(mem_dat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_finished", 32'(finished), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        chk("rst_cycles", 32'(cycles), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        ptr_m = 0;
        chk("start_ld_ready", 32'(ld_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_cycles", 32'(cycles), 0);
        chk("start_timed_out", 32'(timed_out), 0);
    endtask

    task automatic load_bytes(input bit gaps);
        for (int i = 0; i < bq.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    ld_valid  = 1'b0;
                    ld_data   = 8'($urandom);
                    ld_last   = 1'($urandom);
                    start     = 1'($urandom);
                    core_done = 1'($urandom);
                    tick();
                end
            end
            ld_valid  = 1'b1;
            ld_data   = bq[i];
            ld_last   = (i == bq.size() - 1);
            core_done = 1'($urandom);
            wq.push_back('{addr: ptr_m, data: int'(bq[i])});
            ptr_m = (ptr_m + 1) % DEPTH;
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic rst_phase();
        for (int i = 0; i < int'(RST_CYC); i++) begin
            chk("rstph_core_reset", 32'(core_reset), 1);
            chk("rstph_core_req", 32'(core_req), 0);
            chk("rstph_ld_ready", 32'(ld_ready), 0);
            core_done = 1'($urandom);
            tick();
        end
        core_done = 1'b0;
        chk("run_core_reset", 32'(core_reset), 0);
        chk("run_core_req", 32'(core_req), 1);
        chk("run_busy", 32'(busy), 1);
    endtask

    // n_low: RUN cycles with core_done low before it rises (>= TIMEOUT means never).
    task automatic run_core(input int n_low, input bit noise);
        int   n_run;
        fin_t f;
        n_run = (n_low < int'(TIMEOUT)) ? n_low : int'(TIMEOUT);
        f.cyc = n_run;
        f.to  = (n_low >= int'(TIMEOUT)) ? 1 : 0;
        fq.push_back(f);
        for (int i = 0; i < n_run; i++) begin
            core_done = 1'b0;
            if (noise) begin
                start    = 1'($urandom);
                ld_valid = 1'($urandom);
                ld_data  = 8'($urandom);
                ld_last  = 1'($urandom);
            end
            tick();
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (n_low < int'(TIMEOUT)) begin
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
        end
        chk("done_core_reset", 32'(core_reset), 1);
        chk("done_core_req", 32'(core_req), 0);
        chk("done_busy", 32'(busy), 0);
        core_done = 1'($urandom);
        ld_valid  = 1'($urandom);
        repeat (2) tick();
        core_done = 1'b0;
        ld_valid  = 1'b0;
        chk("done_cycles_held", 32'(cycles), f.cyc);
        chk("done_timed_out_held", 32'(timed_out), f.to);
    endtask

    task automatic full_run(input bit gaps, input int n_low, input bit noise);
        do_start();
        load_bytes(gaps);
        rst_phase();
        run_core(n_low, noise);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        ld_last = 1'b0; core_done = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_vals();

        for (int i = 0; i < 5; i++) begin
            ld_valid  = 1'($urandom);
            core_done = 1'($urandom);
            tick();
            chk("idle_core_reset", 32'(core_reset), 1);
            chk("idle_core_req", 32'(core_req), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_ld_ready", 32'(ld_ready), 0);
            chk("idle_cycles", 32'(cycles), 0);
        end
        ld_valid = 1'b0; core_done = 1'b0;

        bq.delete(); bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
        full_run(1'b0, 3, 1'b0);

        bq.delete(); bq.push_back(8'h5C);
        full_run(1'b0, 37, 1'b1);
        full_run(1'b0, TIMEOUT, 1'b0);
        full_run(1'b0, TIMEOUT + 5, 1'b1);
        full_run(1'b0, TIMEOUT - 1, 1'b0);
        full_run(1'b0, 0, 1'b0);

        bq.delete();
        for (int i = 0; i < 6; i++) bq.push_back(8'hA0 + 8'(i));
        full_run(1'b1, 4, 1'b0);

        // Reset mid-run at cycles=5, with an ignored start pulse during RUN.
        bq.delete(); bq.push_back(8'h5A); bq.push_back(8'h5B);
        do_start();
        load_bytes(1'b0);
        rst_phase();
        for (int i = 0; i < 5; i++) begin
            core_done = 1'b0;
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        chk("midrun_cycles", 32'(cycles), 5);
        chk("midrun_core_req", 32'(core_req), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals();
        full_run(1'b0, 6, 1'b1);

        // Reset coinciding with an accepted byte: the write must not appear.
        do_start();
        ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b0;
        check_reset_vals();

        for (int k = 0; k < 6; k++) begin
            int nb;
            nb = $urandom_range(1, 7);
            bq.delete();
            for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
            full_run(1'b1, $urandom_range(0, TIMEOUT + 5), 1'b1);
        end

        tick();
        chk("wr_queue_drained", 32'(wq.size()), 0);
        chk("fin_queue_drained", 32'(fq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Host-side run controller placed directly upstream of the processor top level. It preloads data memory from a byte stream while holding the core in reset. It then releases reset and asserts req, and watches the core's done flag, counting cycles and enforcing a timeout. Its outputs drive the core's reset/req pins and the preload write port of data memory; the top level muxes that port onto dat_mem while core_reset is high.

Parameters:
AW, 8, data-memory address width; the preload pointer is AW bits.
CW, 16, cycle-counter width.
TIMEOUT, 4095, maximum RUN cycles before abort; must be less than 2^CW.
RST_CYC, 2, number of cycles core_reset stays high in RST before RUN; must be at least 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high; returns the block to IDLE.
start  input  1  host request to begin a load+run sequence; sampled only in IDLE or DONE.
ld_valid  input  1  preload byte valid.
ld_data  input  8  preload byte.
ld_last  input  1  marks final preload byte; qualified by ld_valid.
ld_ready  output  1  preload byte accepted when ld_valid and ld_ready are both high.
core_done  input  1  done flag from the core; ignored outside RUN.
core_reset  output  1  drives the core reset; high in every state except RUN.
core_req  output  1  drives core req; high only in RUN.
mem_wr_en  output  1  preload write strobe to data memory (registered).
mem_addr  output  AW  preload write address (registered).
mem_dat  output  8  preload write data (registered).
busy  output  1  high in LOAD, RST and RUN.
finished  output  1  one-cycle pulse on the RUN->DONE transition.
timed_out  output  1  sticky; set when a run aborts by timeout; cleared by start or reset.
cycles  output  CW  RUN-cycle count of the current or last run; held in DONE.

Behaviour:
- States: IDLE, LOAD, RST, RUN, DONE. Encoding is implementer's choice.
- Reset values: state=IDLE, core_reset=1, core_req=0, ld_ready=0, mem_wr_en=0, mem_addr=0, mem_dat=0, busy=0, finished=0, timed_out=0, cycles=0, preload pointer=0, reset counter=0.
- IDLE: start=1 -> LOAD; pointer=0, cycles=0, timed_out=0.
- LOAD: ld_ready=1.
  - On each accepted byte, the next cycle has mem_wr_en=1, mem_addr=pointer, mem_dat=ld_data, and the pointer increments. One cycle of write latency.
  - Pointer wraps from 2^AW-1 to 0 silently; later bytes overwrite.
  - Accepted byte with ld_last=1 -> RST; ld_ready drops the next cycle.
  - No bytes ever offered: the block stays in LOAD indefinitely. There is no load timeout.
- RST: core_reset=1 for exactly RST_CYC cycles, then RUN. The final preload write (issued in the first RST cycle) completes while the core is still in reset.
- RUN: core_reset=0, core_req=1, mem_wr_en=0.
  - Each RUN cycle with core_done=0: cycles increments by 1.
  - If the incremented value equals TIMEOUT: -> DONE, timed_out=1, finished pulses.
  - A RUN cycle with core_done=1: no increment, -> DONE, finished pulses.
  - core_done=1 has priority over timeout in the same cycle.
  - core_done high in the first RUN cycle gives cycles=0.
- DONE: core_reset=1, core_req=0, busy=0; cycles and timed_out are held.
  - start=1 -> LOAD with pointer, cycles and timed_out cleared.
- start is ignored in LOAD, RST and RUN. ld_valid outside LOAD is ignored (ld_ready=0, no writes). core_done outside RUN is ignored.
- reset asserted mid-operation (any state): the next cycle shows all reset values. A pending registered write is dropped (mem_wr_en=0).
- finished is high for exactly one cycle, the first DONE cycle.

Test Plan:
- Reset, then idle 5 cycles -> core_reset=1, core_req=0, busy=0, ld_ready=0, cycles=0 throughout.
- start; send bytes 0x11,0x22,0x33 (last on 0x33), one per cycle -> writes addr 0/1/2 with data 0x11/0x22/0x33 on the cycles after acceptance; core_reset high 2 cycles after LOAD exits; then core_req=1.
- Load 1 byte, hold core_done=0 for 37 RUN cycles then 1 -> finished pulses once, cycles=37, timed_out=0, core_reset=1 in DONE.
- With TIMEOUT=10 and core_done never asserted -> exactly 10 RUN cycles, then DONE with cycles=10, timed_out=1, finished pulse. core_done=1 on that 10th cycle instead -> cycles=9, timed_out=0.
- AW=2: send 6 bytes 0xA0..0xA5 -> addresses 0,1,2,3,0,1. Toggle ld_valid low between bytes -> no extra writes.
- Assert reset during RUN at cycles=5 -> next cycle IDLE with all outputs at reset values. A second start runs normally with cycles restarting at 0. start pulsed during RUN is ignored.
